// File: rtl/vram_plane_ctrl.sv
// CPU-side controller for a stack of bit-plane VRAMs: bank/mask registers,
// CPU read/write sequencing and a hardware fill engine that stalls the CPU.
module vram_plane_ctrl #(
  parameter int         PLANES    = 6,
  parameter int         AW        = 13,
  parameter int         DW        = 8,
  parameter logic [7:0] RDB_PORT  = 8'hF1,
  parameter logic [7:0] WRM_PORT  = 8'hF2,
  parameter logic [7:0] FILL_PORT = 8'hF0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 io_we,
  input  logic [7:0]           io_addr,
  input  logic [DW-1:0]        io_din,
  output logic [DW-1:0]        io_dout,
  input  logic                 cpu_req,
  input  logic                 cpu_wr,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_din,
  output logic [DW-1:0]        cpu_dout,
  output logic                 cpu_ack,
  output logic                 busy,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_din,
  output logic [PLANES-1:0]    mem_we,
  input  logic [PLANES*DW-1:0] mem_q
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, FILL} state_t;

  state_t              state;
  state_t              state_nx;

  logic [DW-1:0]       rd_bank;
  logic [PLANES-1:0]   wr_mask;
  logic [DW-1:0]       fill_val;
  logic [PLANES-1:0]   mask_snap;
  logic [AW-1:0]       fill_cnt;
  logic                fill_last;

  logic                pending;
  logic                pend_wr;
  logic [AW-1:0]       pend_addr;
  logic [DW-1:0]       pend_din;

  logic                wr_ack;
  logic [DW-1:0]       cpu_dout_q;
  logic [DW-1:0]       rd_sel;

  logic                fill_start;
  logic                serve;
  logic                serve_wr;
  logic [AW-1:0]       serve_addr;
  logic [DW-1:0]       serve_din;
  logic                pend_capture;

  // A fill may only start from a quiet IDLE; a request arriving alongside the
  // trigger or during the fill is parked in the pending slot instead.
  assign fill_start   = io_we && (io_addr == FILL_PORT) && (state == IDLE) && !pending;
  assign serve        = (state == IDLE) && (pending || (cpu_req && !fill_start));
  assign serve_wr     = pending ? pend_wr   : cpu_wr;
  assign serve_addr   = pending ? pend_addr : cpu_addr;
  assign serve_din    = pending ? pend_din  : cpu_din;
  assign pend_capture = cpu_req && !pending && ((state == FILL) || fill_start);
  assign fill_last    = &fill_cnt;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < PLANES; i++) begin
      if (rd_bank == DW'(i + 1)) begin
        rd_sel = mem_q[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (fill_start) begin
          state_nx = FILL;
        end else if (serve && !serve_wr) begin
          state_nx = RD_WAIT;
        end
      end
      RD_WAIT: state_nx = RD_DONE;
      RD_DONE: state_nx = IDLE;
      FILL: begin
        if (fill_last) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = '0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (serve) begin
          mem_addr = serve_addr;
          if (serve_wr) begin
            mem_din = serve_din;
            mem_we  = wr_mask;
          end
        end
      end
      FILL: begin
        mem_addr = fill_cnt;
        mem_din  = fill_val;
        mem_we   = mask_snap;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_ack  = wr_ack || (state == RD_DONE);
  assign cpu_dout = cpu_dout_q;

  // The running fill works from its own mask snapshot so later writes to the
  // mask register only affect CPU writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_bank    <= '0;
      wr_mask    <= '0;
      fill_val   <= '0;
      mask_snap  <= '0;
      fill_cnt   <= '0;
      pending    <= 1'b0;
      pend_wr    <= 1'b0;
      pend_addr  <= '0;
      pend_din   <= '0;
      wr_ack     <= 1'b0;
      cpu_dout_q <= '0;
    end else begin
      if (io_we && (io_addr == RDB_PORT)) begin
        rd_bank <= io_din;
      end
      if (io_we && (io_addr == WRM_PORT)) begin
        wr_mask <= io_din[PLANES-1:0];
      end

      if (fill_start) begin
        fill_val  <= io_din;
        mask_snap <= wr_mask;
        fill_cnt  <= '0;
      end else if (state == FILL) begin
        fill_cnt <= fill_cnt + AW'(1);
      end

      if (pend_capture) begin
        pending   <= 1'b1;
        pend_wr   <= cpu_wr;
        pend_addr <= cpu_addr;
        pend_din  <= cpu_din;
      end else if (serve && pending) begin
        pending <= 1'b0;
      end

      wr_ack <= serve && serve_wr;

      if (state == RD_WAIT) begin
        cpu_dout_q <= rd_sel;
      end
    end
  end

  always_comb begin
    io_dout = '1;
    if (io_addr == FILL_PORT) begin
      io_dout         = '0;
      io_dout[DW-1]   = busy;
    end else if (io_addr == RDB_PORT) begin
      io_dout = rd_bank;
    end else if (io_addr == WRM_PORT) begin
      io_dout             = '0;
      io_dout[PLANES-1:0] = wr_mask;
    end
  end

endmodule

// File: doc/vram_plane_ctrl.md
Name: vram_plane_ctrl

Overview:
Parametrised multi-plane VRAM controller. It owns the CPU side of N bit-plane VRAMs: the read-bank select, the write-plane mask and CPU read/write sequencing. It adds a hardware fill engine that clears or fills all masked planes, with the CPU stalled by handshake while the fill runs. It sits between the Z80 bus decode and the plane dpram A-ports; the video scan B-ports are untouched.

Parameters:
PLANES, 6, number of bit-plane RAMs (1..8)
AW, 13, plane address width (words per plane = 2^AW)
DW, 8, data width
RDB_PORT, 8'hF1, I/O address of read-bank register
WRM_PORT, 8'hF2, I/O address of write-mask register
FILL_PORT, 8'hF0, I/O address of fill trigger/status register

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
io_we  in  1  one-cycle I/O write strobe
io_addr  in  8  I/O port address
io_din  in  DW  I/O write data
io_dout  out  DW  I/O read data, combinational: {busy, 0...} at FILL_PORT, rd_bank at RDB_PORT, wr_mask at WRM_PORT, else all-ones
cpu_req  in  1  one-cycle VRAM access request
cpu_wr  in  1  1=write, 0=read; sampled with cpu_req
cpu_addr  in  AW  plane word address; sampled with cpu_req
cpu_din  in  DW  write data; sampled with cpu_req
cpu_dout  out  DW  registered read data; valid while cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse
busy  out  1  fill engine active
mem_addr  out  AW  shared address to all plane A-ports
mem_din  out  DW  shared write data
mem_we  out  PLANES  per-plane write enable, active-high
mem_q  in  PLANES*DW  plane read data (synchronous, 1-cycle latency); plane i at [i*DW +: DW]

Behaviour:
- Reset (async assert, sync release): rd_bank=0, wr_mask=0, fill_val=0, state=IDLE, pending=0; all outputs 0 except io_dout (combinational).
- I/O writes: RDB_PORT -> rd_bank; WRM_PORT -> wr_mask (low PLANES bits used); FILL_PORT -> fill_val=io_din and fill start if IDLE and no access in flight, otherwise ignored entirely (fill_val unchanged).
- Read plane select: rd_bank=k with 1<=k<=PLANES selects plane k-1; any other value selects none and read returns 0.
- States: IDLE, RD_WAIT, RD_DONE, FILL.
- IDLE + cpu_req read: mem_addr=cpu_addr that cycle (t). t+1 RD_WAIT. t+2 RD_DONE: cpu_dout=selected plane mem_q, cpu_ack=1. Next cycle IDLE. Latency is 2 cycles.
- IDLE + cpu_req write: mem_addr/mem_din driven and mem_we=wr_mask at t. cpu_ack=1 at t+1. Writes with wr_mask=0 still ack.
- Back-to-back: a cpu_req in the cycle after an ack is accepted. A cpu_req while a read is in flight is a protocol violation and is ignored.
- FILL: busy=1 from the cycle after the trigger. wr_mask is snapshotted at the trigger. The address counter runs 0..2^AW-1, one word per cycle, mem_we=snapshot mask, mem_din=fill_val. busy drops and state returns to IDLE the cycle after address 2^AW-1 is written, so the fill takes exactly 2^AW cycles. Counter wrap ends the fill and does not restart it.
- cpu_req during FILL (or in the same cycle as the trigger): captured into a one-deep pending slot (wr, addr, din). It is served starting the first IDLE cycle after the fill, using the live wr_mask/rd_bank. A second cpu_req while pending=1 is dropped.
- I/O writes to RDB_PORT/WRM_PORT during the fill update the registers but do not affect the running fill.
- Reset mid-fill or mid-read: aborts immediately, mem_we=0, no ack, pending cleared.

Test Plan:
- Reset, then wr_mask=0x05, write addr 0x0123 data 0xA5 -> mem_we=6'b000101 for 1 cycle, cpu_ack at t+1; read with rd_bank=3 returns 0xA5 at t+2 with ack.
- rd_bank=0 and rd_bank=7 (PLANES=6), read any address -> cpu_dout=0x00, ack at t+2.
- wr_mask=0x3F, FILL_PORT<=0x00 -> busy for exactly 8192 cycles, mem_addr sweeps 0..0x1FFF, mem_we=0x3F each cycle; io_dout at FILL_PORT reads 0x80 while busy, 0x00 after.
- During fill: cpu_req write 0x0010/0x5A at cycle 100 -> no ack until the fill ends; write then issued with ack; a second req at cycle 101 produces no memory activity.
- wr_mask changed to 0x01 at fill cycle 10 -> fill still writes 0x3F; the later pending write uses 0x01; FILL_PORT write mid-fill ignored.
- reset_n low at fill cycle 500 -> busy=0 and mem_we=0 immediately; after release, registers read 0 and the next request completes normally.
